// File: rtl/commu_pkg.sv
// commu_pkg: shared state encoding, CRC constants and CRC step function
// for the commu transmit path.
package commu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } tx_state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] LEN_CRC  = 16'd2;

    // CRC-16/CCITT over one byte, MSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/commu_crc16.sv
// commu_crc16: running CRC-16/CCITT accumulator, one byte per cycle.
module commu_crc16
    import commu_pkg::*;
(
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc
);

    // Restart on clear, otherwise fold in each valid byte.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (byte_vld) begin
            crc <= crc16_step(crc, byte_in);
        end
    end

endmodule

// File: rtl/commu_tx_sched.sv
// commu_tx_sched: paces packet bytes at the bit-slot rate, fetches each
// byte through rd_req/rd_ack and rotates the device slot per packet.
// Optional build macro COMMU_TX_CRC_EN: the last two byte positions carry
// an internally generated CRC-16/CCITT instead of fetched data.
module commu_tx_sched
    import commu_pkg::*;
#(
    parameter int PRESC_DIV = 50,
    parameter int ACK_TO    = 16
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [15:0] len_pkg,
    input  logic [19:0] tbit_period,
    input  logic [7:0]  cfg_numDev,
    input  logic        pkg_start,
    output logic        pkg_busy,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic [7:0]  rd_data,
    output logic        tx_vld,
    output logic [7:0]  tx_data,
    output logic [7:0]  tx_slot,
    output logic        pkg_done,
    output logic        err_underrun
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int TW = $clog2(ACK_TO + 1);

    tx_state_t     state;
    logic [15:0]   len_l;
    logic [15:0]   byte_cnt;
    logic [19:0]   per_l;
    logic [19:0]   bit_cnt;
    logic [PW-1:0] presc_cnt;
    logic [TW-1:0] to_cnt;
    logic          strobe_pend;
    logic          tick;
    logic          bit_strobe;
    logic [15:0]   cnt_inc;
    logic [8:0]    slot_inc;
    logic [8:0]    num_eff;
    logic [7:0]    slot_next;

    // Timing chain only runs while a packet is active.
    assign tick       = (state != ST_IDLE) && (presc_cnt == PW'(PRESC_DIV - 1));
    assign bit_strobe = tick && (bit_cnt == per_l - 20'd1);
    assign cnt_inc    = byte_cnt + 16'd1;
    assign slot_inc   = {1'b0, tx_slot} + 9'd1;
    assign num_eff    = (cfg_numDev == 8'd0) ? 9'd1 : {1'b0, cfg_numDev};
    assign slot_next  = (slot_inc >= num_eff) ? 8'd0 : slot_inc[7:0];

`ifdef COMMU_TX_CRC_EN
    logic [15:0] crc;
    logic        crc_pos;
    logic [7:0]  crc_byte;

    // Flag the trailing CRC positions and select high byte first, then low.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        crc_pos  = 1'b0;
        crc_byte = crc[7:0];
        if (len_l >= LEN_CRC && byte_cnt >= len_l - LEN_CRC) begin
            crc_pos = 1'b1;
            if (byte_cnt == len_l - LEN_CRC) begin
                crc_byte = crc[15:8];
            end
        end
    end

    commu_crc16 u_crc (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .clear    (state == ST_IDLE && pkg_start),
        .byte_vld (state == ST_EMIT && !crc_pos),
        .byte_in  (tx_data),
        .crc      (crc)
    );
`endif

    // Prescaler and bit timer: held at zero in IDLE so every packet restarts them.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        // NOTE: sequential state uses <= so every register sees pre-edge values.
        if (!rst_n) begin
            presc_cnt <= '0;
            bit_cnt   <= '0;
        end else if (state == ST_IDLE) begin
            presc_cnt <= '0;
            bit_cnt   <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) begin
                bit_cnt <= bit_strobe ? 20'd0 : bit_cnt + 20'd1;
            end
        end
    end

    // Packet FSM with registered outputs, strobe-overrun tracking and slot rotation.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            len_l        <= '0;
            per_l        <= '0;
            byte_cnt     <= '0;
            to_cnt       <= '0;
            strobe_pend  <= 1'b0;
            pkg_busy     <= 1'b0;
            rd_req       <= 1'b0;
            tx_vld       <= 1'b0;
            tx_data      <= '0;
            tx_slot      <= '0;
            pkg_done     <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            tx_vld   <= 1'b0;
            pkg_done <= 1'b0;
            // A strobe that WAIT cannot take is parked; a second one is lost.
            if (bit_strobe && state != ST_WAIT) begin
                if (strobe_pend) begin
                    err_underrun <= 1'b1;
                end else begin
                    strobe_pend <= 1'b1;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (pkg_start) begin
                        len_l        <= len_pkg;
                        per_l        <= (tbit_period == 20'd0) ? 20'd1 : tbit_period;
                        byte_cnt     <= '0;
                        err_underrun <= 1'b0;
                        strobe_pend  <= 1'b0;
                        pkg_busy     <= 1'b1;
                        state        <= (len_pkg == 16'd0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bit_strobe || strobe_pend) begin
                        // Consume the parked strobe; a coincident new one stays parked.
                        strobe_pend <= bit_strobe && strobe_pend;
`ifdef COMMU_TX_CRC_EN
                        if (crc_pos) begin
                            tx_vld  <= 1'b1;
                            tx_data <= crc_byte;
                            state   <= ST_EMIT;
                        end else
`endif
                        begin
                            rd_req <= 1'b1;
                            to_cnt <= '0;
                            state  <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (rd_ack) begin
                        rd_req  <= 1'b0;
                        tx_vld  <= 1'b1;
                        tx_data <= rd_data;
                        state   <= ST_EMIT;
                    end else if (to_cnt == TW'(ACK_TO - 1)) begin
                        rd_req       <= 1'b0;
                        tx_vld       <= 1'b1;
                        tx_data      <= 8'h00;
                        err_underrun <= 1'b1;
                        state        <= ST_EMIT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_EMIT: begin
                    byte_cnt <= cnt_inc;
                    state    <= (cnt_inc == len_l) ? ST_DONE : ST_WAIT;
                end
                ST_DONE: begin
                    pkg_done <= 1'b1;
                    pkg_busy <= 1'b0;
                    tx_slot  <= slot_next;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
